// File: rtl/dump_pkg.sv
// Shared types and helpers for the state dump unit.
// Holds the scan FSM state encoding, the beat source encodings and an
// index-width helper that never returns zero so one-entry tables still get a port.
package dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REG_SCAN,
    MEM_SCAN,
    DRAIN,
    DONE
  } state_t;

  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Width of an index able to address n entries; at least one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dump_stream_reg.sv
// Output hold register for dump beats: src/idx/data/valid.
// Latency: one cycle from load to valid. Backpressure: a held beat stays
// stable while valid && !ready; the register is refilled only when empty or accepted.
// Ports: clk, rst (sync, active-high), load + ld_* (next beat), ready (consumer),
//        valid/src/idx/data (registered beat).
module dump_stream_reg
  import dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              ld_src,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ready,
  output logic              valid,
  output logic              src,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      src   <= SRC_REG;
      idx   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      src   <= ld_src;
      idx   <= ld_idx;
      data  <= ld_data;
    end else if (ready) begin
      // Beat accepted with nothing behind it: register empties, payload kept.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/state_dump_unit.sv
// Freezes the CPU and streams every register-file entry, then every data-memory
// word, over valid/ready; starts at a programmed cycle or on trig_i.
// Latency: freeze the cycle after the trigger edge, first beat one cycle later,
// one beat per cycle with ready high. Backpressure: scan stalls while the held beat is refused.
// Ports: clk_i/rst_i/trig_i; reg_addr_o/reg_data_i and mem_addr_o/mem_data_i (combinational
//        read taps); dump_* (beat stream); freeze_o (CPU stall); done_o (sticky); cycle_o.
module state_dump_unit
  import dump_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_N      = 32,
  parameter int MEM_N      = 32,
  parameter int TRIG_CYCLE = 650
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           trig_i,
  output logic [idx_w(REG_N)-1:0]                        reg_addr_o,
  input  logic [DATA_W-1:0]                              reg_data_i,
  output logic [idx_w(MEM_N)-1:0]                        mem_addr_o,
  input  logic [DATA_W-1:0]                              mem_data_i,
  output logic                                           dump_valid_o,
  input  logic                                           dump_ready_i,
  output logic                                           dump_src_o,
  output logic [idx_w((REG_N > MEM_N) ? REG_N : MEM_N)-1:0] dump_idx_o,
  output logic [DATA_W-1:0]                              dump_data_o,
  output logic                                           freeze_o,
  output logic                                           done_o,
  output logic [31:0]                                    cycle_o
);

  localparam int IDX_W = idx_w((REG_N > MEM_N) ? REG_N : MEM_N);
  localparam int RA_W  = idx_w(REG_N);
  localparam int MA_W  = idx_w(MEM_N);
  localparam logic [IDX_W-1:0] REG_LAST   = IDX_W'(REG_N - 1);
  localparam logic [IDX_W-1:0] MEM_LAST   = IDX_W'(MEM_N - 1);
  localparam logic [31:0]      TRIG_MATCH = 32'(TRIG_CYCLE - 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [31:0]        cycle;
  logic               load;
  logic               ld_src;
  logic [DATA_W-1:0]  ld_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx   <= '0;
      cycle <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cycle <= cycle + 32'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    load       = 1'b0;
    ld_src     = SRC_REG;
    ld_data    = reg_data_i;
    reg_addr_o = '0;
    mem_addr_o = '0;
    freeze_o   = 1'b0;
    done_o     = 1'b0;

    case (state)
      IDLE: begin
        // Counter match and trig_i in the same cycle collapse into one start.
        if (trig_i || (cycle == TRIG_MATCH)) begin
          state_nxt = REG_SCAN;
          idx_nxt   = '0;
        end
      end
      REG_SCAN: begin
        freeze_o   = 1'b1;
        reg_addr_o = idx[RA_W-1:0];
        load       = !dump_valid_o || dump_ready_i;
        if (load) begin
          if (idx == REG_LAST) begin
            state_nxt = MEM_SCAN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      MEM_SCAN: begin
        freeze_o   = 1'b1;
        mem_addr_o = idx[MA_W-1:0];
        ld_src     = SRC_MEM;
        ld_data    = mem_data_i;
        load       = !dump_valid_o || dump_ready_i;
        if (load) begin
          if (idx == MEM_LAST) begin
            state_nxt = DRAIN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Last beat is sitting in the output register; stay frozen until it goes.
        freeze_o = 1'b1;
        if (dump_ready_i) state_nxt = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (trig_i) begin
          state_nxt = REG_SCAN;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cycle_o = cycle;

  dump_stream_reg #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_stream (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (load),
    .ld_src (ld_src),
    .ld_idx (idx),
    .ld_data(ld_data),
    .ready  (dump_ready_i),
    .valid  (dump_valid_o),
    .src    (dump_src_o),
    .idx    (dump_idx_o),
    .data   (dump_data_o)
  );

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: a 32/32 instance driven through auto, manual,
// backpressured, reset-abort and simultaneous-start dumps against a beat
// scoreboard, plus a REG_N=1/MEM_N=4/16-bit instance checked beat by beat.
module tb_state_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Main instance
  logic        m_trig, m_ready;
  logic [4:0]  m_reg_addr, m_mem_addr, m_idx;
  logic [31:0] m_reg_data, m_mem_data, m_data, m_cycle;
  logic        m_valid, m_src, m_freeze, m_done;
  logic [31:0] roff, moff;

  assign m_reg_data = 32'(m_reg_addr) + roff;
  assign m_mem_data = 32'(m_mem_addr) * 32'd3 + moff;

  state_dump_unit #(
    .DATA_W(32), .REG_N(32), .MEM_N(32), .TRIG_CYCLE(650)
  ) u_main (
    .clk_i(clk), .rst_i(rst), .trig_i(m_trig),
    .reg_addr_o(m_reg_addr), .reg_data_i(m_reg_data),
    .mem_addr_o(m_mem_addr), .mem_data_i(m_mem_data),
    .dump_valid_o(m_valid), .dump_ready_i(m_ready),
    .dump_src_o(m_src), .dump_idx_o(m_idx), .dump_data_o(m_data),
    .freeze_o(m_freeze), .done_o(m_done), .cycle_o(m_cycle)
  );

  // Corner instance
  logic        c_trig, c_ready;
  logic [0:0]  c_reg_addr;
  logic [1:0]  c_mem_addr, c_idx;
  logic [15:0] c_reg_data, c_mem_data, c_data;
  logic        c_valid, c_src, c_freeze, c_done;
  logic [31:0] c_cycle;

  assign c_reg_data = 16'(c_reg_addr) + 16'd100;
  assign c_mem_data = 16'hF000 + 16'(c_mem_addr) * 16'd3;

  state_dump_unit #(
    .DATA_W(16), .REG_N(1), .MEM_N(4), .TRIG_CYCLE(5)
  ) u_corner (
    .clk_i(clk), .rst_i(rst), .trig_i(c_trig),
    .reg_addr_o(c_reg_addr), .reg_data_i(c_reg_data),
    .mem_addr_o(c_mem_addr), .mem_data_i(c_mem_data),
    .dump_valid_o(c_valid), .dump_ready_i(c_ready),
    .dump_src_o(c_src), .dump_idx_o(c_idx), .dump_data_o(c_data),
    .freeze_o(c_freeze), .done_o(c_done), .cycle_o(c_cycle)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected beats for the main instance
  typedef struct packed {
    logic        src;
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    nbeats = 0;

  task automatic push_dump(input logic [31:0] ro, input logic [31:0] mo);
    for (int k = 0; k < 32; k++) exp_q.push_back({1'b0, 5'(k), 32'(k) + ro});
    for (int k = 0; k < 32; k++) exp_q.push_back({1'b1, 5'(k), 32'(k) * 32'd3 + mo});
  endtask

  // Ready pattern: 0 = held high, 1 = 1,0,0 repeating, 2 = held low
  int mode = 0;
  int pc   = 0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0:       m_ready = 1'b1;
        1: begin m_ready = ((pc % 3) == 0); pc++; end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Beat monitor: pops on each handshake, checks hold stability while stalled
  logic  stall_prev = 1'b0;
  beat_t held;
  always @(negedge clk) begin : mon
    beat_t cur;
    beat_t e;
    cur = {m_src, m_idx, m_data};
    if (stall_prev) chk("hold_stable", 64'(cur), 64'(held));
    if (m_valid && m_ready && !rst) begin
      chk("scoreboard_avail", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("beat_%0d", nbeats), 64'(cur), 64'(e));
      end
      nbeats++;
    end
    stall_prev = m_valid && !m_ready && !rst;
    held       = cur;
  end

  // Pulse trig_i so that it is sampled on the edge where cycle_o == c.
  task automatic pulse_trig_at(input int c);
    for (int i = 0; i < 1000 && m_cycle != 32'(c - 1); i++) @(negedge clk);
    chk("trig_wait", m_cycle, 64'(c - 1));
    @(posedge clk); #1 m_trig = 1'b1;
    @(posedge clk); #1 m_trig = 1'b0;
  endtask

  int base;

  initial begin
    rst = 1'b1; m_trig = 1'b0; c_trig = 1'b0; c_ready = 1'b1;
    roff = 32'd100; moff = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",   m_valid, 0);
    chk("rst_freeze",  m_freeze, 0);
    chk("rst_done",    m_done, 0);
    chk("rst_cycle",   m_cycle, 0);
    chk("rst_regaddr", m_reg_addr, 0);
    chk("rst_idx",     m_idx, 0);
    chk("rst_c_valid", c_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    push_dump(32'd100, 32'd0);
    base = nbeats;

    // Corner instance: 1 register + 4 memory words, 16-bit, auto start at 5
    for (int i = 0; i < 20 && !c_valid; i++) @(negedge clk);
    chk("c_first_cycle", c_cycle, 6);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("c_valid_%0d", j), c_valid, 1);
      chk($sformatf("c_src_%0d", j),   c_src, (j == 0) ? 0 : 1);
      chk($sformatf("c_idx_%0d", j),   c_idx, (j == 0) ? 0 : j - 1);
      chk($sformatf("c_data_%0d", j),  c_data,
          (j == 0) ? 64'd100 : 64'(16'hF000 + 16'(3 * (j - 1))));
      @(negedge clk);
    end
    chk("c_done",       c_done, 1);
    chk("c_done_cycle", c_cycle, 11);
    chk("c_freeze_off", c_freeze, 0);
    chk("c_valid_off",  c_valid, 0);

    // Auto trigger at 650, ready held high
    for (int i = 0; i < 700 && !m_freeze; i++) @(negedge clk);
    chk("a_freeze_cycle", m_cycle, 650);
    chk("a_valid_not_yet", m_valid, 0);
    @(negedge clk);
    chk("a_first_valid", m_valid, 1);
    chk("a_first_cycle", m_cycle, 651);
    for (int i = 0; i < 100 && !m_done; i++) @(negedge clk);
    chk("a_done_cycle", m_cycle, 715);
    chk("a_freeze_off", m_freeze, 0);
    chk("a_valid_off",  m_valid, 0);
    chk("a_regaddr_0",  m_reg_addr, 0);
    chk("a_memaddr_0",  m_mem_addr, 0);
    chk("a_beats",      nbeats - base, 64);
    chk("a_q_empty",    exp_q.size(), 0);

    // Restart from DONE with backpressure and new contents; mid-dump trig ignored
    roff = 32'd200; moff = 32'd7; mode = 1;
    push_dump(32'd200, 32'd7);
    base = nbeats;
    @(posedge clk); #1 m_trig = 1'b1;
    @(posedge clk); #1 m_trig = 1'b0;
    @(negedge clk);
    chk("b_done_clear", m_done, 0);
    chk("b_freeze",     m_freeze, 1);
    repeat (20) @(posedge clk);
    #1 m_trig = 1'b1;
    @(posedge clk); #1 m_trig = 1'b0;
    for (int i = 0; i < 400 && !m_done; i++) @(negedge clk);
    chk("b_done",    m_done, 1);
    chk("b_beats",   nbeats - base, 64);
    chk("b_q_empty", exp_q.size(), 0);
    mode = 0;

    // Manual trigger at cycle 10; counter match at 650 must not restart
    @(posedge clk); #1 rst = 1'b1;
    roff = 32'd300; moff = 32'd11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_dump(32'd300, 32'd11);
    base = nbeats;
    pulse_trig_at(10);
    @(negedge clk);
    chk("c_freeze_rise",  m_freeze, 1);
    chk("c_freeze_cycle", m_cycle, 11);
    for (int i = 0; i < 100 && !m_done; i++) @(negedge clk);
    chk("m_done_cycle", m_cycle, 76);
    chk("m_beats",      nbeats - base, 64);
    for (int i = 0; i < 700 && m_cycle < 32'd660; i++) @(negedge clk);
    chk("m_no_auto_done",   m_done, 1);
    chk("m_no_auto_freeze", m_freeze, 0);
    chk("m_no_auto_beats",  nbeats - base, 64);

    // Auto dump aborted by reset after beat 20
    @(posedge clk); #1 rst = 1'b1;
    roff = 32'd400; moff = 32'd5;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    push_dump(32'd400, 32'd5);
    base = nbeats;
    for (int i = 0; i < 700 && !m_freeze; i++) @(negedge clk);
    chk("r_freeze_cycle", m_cycle, 650);
    for (int i = 0; i < 100 && (nbeats - base) < 20; i++) begin
      @(posedge clk); #3;
    end
    rst = 1'b1; mode = 2;
    @(posedge clk);
    @(negedge clk);
    chk("r_valid_0",  m_valid, 0);
    chk("r_freeze_0", m_freeze, 0);
    chk("r_cycle_0",  m_cycle, 0);
    chk("r_beats_20", nbeats - base, 20);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    mode = 0;
    push_dump(32'd400, 32'd5);
    base = nbeats;

    // trig_i on the same edge as the counter match: one dump only
    pulse_trig_at(649);
    @(negedge clk);
    chk("s_freeze",       m_freeze, 1);
    chk("s_freeze_cycle", m_cycle, 650);
    for (int i = 0; i < 200 && !m_done; i++) @(negedge clk);
    chk("s_done_cycle", m_cycle, 715);
    repeat (10) @(negedge clk);
    chk("s_beats",   nbeats - base, 64);
    chk("s_q_empty", exp_q.size(), 0);
    chk("s_done",    m_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
